// File: rtl/my_security_keypad_pkg.sv
// Shared types and constants for the keypad code-entry front end.
// Holds the FSM state encoding, the KEY word constants and the
// press-decoding helpers used by the top level.
package my_security_keypad_pkg;

  localparam int unsigned N_BTN  = 4;
  localparam int unsigned DIG_W  = 2;
  localparam int unsigned N_DIG  = 4;
  localparam int unsigned CODE_W = N_DIG * DIG_W;
  localparam int unsigned CNT_W  = 3;

  // KEY word driven to the security FSM; only these two values ever appear.
  localparam logic [1:0] KEY_DISARM = 2'b00;
  localparam logic [1:0] KEY_ARM    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // Digit carried by a press vector; highest set index when several collide.
  function automatic logic [DIG_W-1:0] press_digit(input logic [N_BTN-1:0] p);
    logic [DIG_W-1:0] d;
    d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (p[i]) d = DIG_W'(i);
    end
    return d;
  endfunction

  // More than one button edge in the same cycle.
  function automatic logic press_multi(input logic [N_BTN-1:0] p);
    return ($countones(p) > 1);
  endfunction

endpackage

// File: rtl/my_security_keypad_debounce.sv
// my_debounce: 2-FF synchronizer, stability counter and rising-edge pulse
// for one raw push-button.
//   clk, rst_n : clock, async active-low reset
//   btn        : raw asynchronous button (active high)
//   press      : registered 1-cycle pulse on a debounced 0->1 transition
module my_debounce #(
  parameter int unsigned DB_CYC = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_MAX = (DB_CYC > 1) ? DB_CYC - 1 : 0;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          press_q, press_d;

  // Count consecutive cycles where the synchronized input differs from the
  // debounced level; the level follows once the difference lasted DB_CYC cycles.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(CNT_MAX)) db_d = sync2_q;
      else                       cnt_d = cnt_q + CW'(1);
    end
    press_d = db_d & ~db_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/my_security_keypad.sv
// my_security_keypad: debounces four buttons, collects a 4-digit code and
// toggles the KEY word (disarmed/armed) on a correct entry, with an
// inter-press timeout and a lockout after repeated wrong codes.
//   CLK, RST : clock, async active-low reset
//   BTN      : raw buttons, BTN[i] enters digit i
//   KEY      : 2'b00 disarmed, 2'b11 armed
//   OK / ERR : 1-cycle pulses on correct / wrong code
//   LOCKED   : high during lockout
//   DIG_CNT  : digits entered so far (0..4)
module my_security_keypad
  import my_security_keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter logic [7:0]  CODE        = 8'h1B,
  parameter int unsigned TIMEOUT_SEC = 5,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_SEC    = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN,
  output logic [1:0]       KEY,
  output logic             OK,
  output logic             ERR,
  output logic             LOCKED,
  output logic [CNT_W-1:0] DIG_CNT
);

  localparam int unsigned DB_CYC = CLK_FREQ * DEBOUNCE_MS / 1000;
  localparam int unsigned TO_CYC = TIMEOUT_SEC * CLK_FREQ;
  localparam int unsigned LK_CYC = LOCK_SEC * CLK_FREQ;
  localparam int unsigned TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int unsigned LK_W   = (LK_CYC > 1) ? $clog2(LK_CYC) : 1;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  logic [N_BTN-1:0]  press;
  logic              any_press, multi;
  logic [DIG_W-1:0]  digit;
  logic              to_exp, lk_exp, match, fail_hit;
  logic [FAIL_W-1:0] fail_inc;

  state_e             state_q, state_d;
  logic [1:0]         key_q, key_d;
  logic               ok_q, ok_d, err_q, err_d, locked_q, locked_d;
  logic [CNT_W-1:0]   dig_cnt_q, dig_cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               inv_q, inv_d;
  logic [TO_W-1:0]    to_tmr_q, to_tmr_d;
  logic [LK_W-1:0]    lk_tmr_q, lk_tmr_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_db
    my_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk   (CLK),
      .rst_n (RST),
      .btn   (BTN[i]),
      .press (press[i])
    );
  end

  // Timers count elapsed cycles from 0, so expiry sits at terminal count - 1.
  assign any_press = |press;
  assign multi     = press_multi(press);
  assign digit     = press_digit(press);
  assign to_exp    = (to_tmr_q == TO_W'(TO_CYC - 1));
  assign lk_exp    = (lk_tmr_q == LK_W'(LK_CYC - 1));
  assign match     = (code_q == CODE) && !inv_q;
  assign fail_inc  = fail_q + FAIL_W'(1);
  assign fail_hit  = (fail_inc == FAIL_W'(MAX_FAIL));

  // State register and datapath flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      key_q     <= KEY_DISARM;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      dig_cnt_q <= '0;
      code_q    <= '0;
      inv_q     <= 1'b0;
      to_tmr_q  <= '0;
      lk_tmr_q  <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      dig_cnt_q <= dig_cnt_d;
      code_q    <= code_d;
      inv_q     <= inv_d;
      to_tmr_q  <= to_tmr_d;
      lk_tmr_q  <= lk_tmr_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state logic; a press beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (any_press) state_d = ST_ENTRY;
      ST_ENTRY: begin
        if (any_press && dig_cnt_q == CNT_W'(N_DIG - 1)) state_d = ST_CHECK;
        else if (!any_press && to_exp)                   state_d = ST_IDLE;
      end
      ST_CHECK:   state_d = (match || !fail_hit) ? ST_IDLE : ST_LOCKOUT;
      ST_LOCKOUT: if (lk_exp) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    key_d     = key_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    locked_d  = (state_d == ST_LOCKOUT);
    dig_cnt_d = dig_cnt_q;
    code_d    = code_q;
    inv_d     = inv_q;
    to_tmr_d  = '0;
    lk_tmr_d  = '0;
    fail_d    = fail_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          code_d    = {code_q[CODE_W-DIG_W-1:0], digit};
          inv_d     = multi;
          dig_cnt_d = CNT_W'(1);
        end
      end
      ST_ENTRY: begin
        if (any_press) begin
          code_d    = {code_q[CODE_W-DIG_W-1:0], digit};
          inv_d     = inv_q | multi;
          dig_cnt_d = dig_cnt_q + CNT_W'(1);
        end else if (to_exp) begin
          dig_cnt_d = '0;
        end else begin
          to_tmr_d  = to_tmr_q + TO_W'(1);
        end
      end
      ST_CHECK: begin
        dig_cnt_d = '0;
        if (match) begin
          key_d  = (key_q == KEY_ARM) ? KEY_DISARM : KEY_ARM;
          ok_d   = 1'b1;
          fail_d = '0;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc;
        end
      end
      ST_LOCKOUT: begin
        if (lk_exp) fail_d   = '0;
        else        lk_tmr_d = lk_tmr_q + LK_W'(1);
      end
      default: ;
    endcase
  end

  assign KEY     = key_q;
  assign OK      = ok_q;
  assign ERR     = err_q;
  assign LOCKED  = locked_q;
  assign DIG_CNT = dig_cnt_q;

endmodule

// File: tb/tb_my_security_keypad.sv
// Directed bench for my_security_keypad with a result scoreboard.
module tb_my_security_keypad;

  localparam logic [7:0] CODE_T   = 8'h1B;
  localparam int         LOCK_CYC = 10000;
  localparam int         N_FAIL   = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] BTN = 4'b0000;
  logic [1:0] KEY;
  logic       OK, ERR, LOCKED;
  logic [2:0] DIG_CNT;

  my_security_keypad #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(5), .CODE(CODE_T),
    .TIMEOUT_SEC(5), .MAX_FAIL(N_FAIL), .LOCK_SEC(10)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .KEY(KEY), .OK(OK),
    .ERR(ERR), .LOCKED(LOCKED), .DIG_CNT(DIG_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ok;
    logic [1:0] key;
    logic       lock;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rise_cyc = 0, fall_cyc = 0;
  bit   fell = 1'b0;
  logic ok_prev = 1'b0, err_prev = 1'b0, lk_prev = 1'b0;

  // Reference model state
  logic [1:0] key_m  = 2'b00;
  int         fail_m = 0;
  int         dc_m   = 0;
  logic [7:0] code_m = 8'h00;
  logic       inv_m  = 1'b0;
  logic       lock_m = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on every OK/ERR pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      ok_prev = 1'b0; err_prev = 1'b0; lk_prev = 1'b0;
    end else begin
      if (OK || ERR) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_result: observed ok=%0b err=%0b expected no result", OK, ERR);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("result_ok", OK, e.ok);
          chk("result_err", ERR, !e.ok);
          chk("result_key", KEY, e.key);
          chk("result_locked", LOCKED, e.lock);
        end
        chk("pulse_width", ok_prev | err_prev, 0);
      end
      if (LOCKED && !lk_prev) rise_cyc = cyc;
      if (!LOCKED && lk_prev) begin fall_cyc = cyc; fell = 1'b1; end
      ok_prev = OK; err_prev = ERR; lk_prev = LOCKED;
    end
  end

  // Drive one button pattern, update the model, check DIG_CNT afterwards.
  task automatic press(input logic [3:0] b);
    logic [1:0] d;
    logic       multi;
    exp_t       e;
    multi = ($countones(b) > 1);
    d = 2'd0;
    for (int i = 0; i < 4; i++) if (b[i]) d = 2'(i);
    if (!lock_m) begin
      if (dc_m == 0) inv_m = 1'b0;
      code_m = {code_m[5:0], d};
      inv_m  = inv_m | multi;
      dc_m++;
      if (dc_m == 4) begin
        e.ok = !inv_m && (code_m == CODE_T);
        if (e.ok) begin key_m = ~key_m; fail_m = 0; end
        else fail_m++;
        lock_m = (fail_m == N_FAIL);
        e.key  = key_m;
        e.lock = lock_m;
        sb_q.push_back(e);
        dc_m = 0;
      end
    end
    @(negedge CLK) BTN = b;
    repeat (20) @(negedge CLK);
    BTN = 4'b0000;
    repeat (30) @(negedge CLK);
    chk("dig_cnt", DIG_CNT, dc_m);
  endtask

  task automatic enter_code(input logic [7:0] c);
    for (int k = 3; k >= 0; k--) press(4'b0001 << c[2*k +: 2]);
  endtask

  task automatic model_reset();
    key_m = 2'b00; fail_m = 0; dc_m = 0; lock_m = 1'b0; inv_m = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (5) @(negedge CLK);
    chk("rst_key", KEY, 2'b00);
    chk("rst_ok", OK, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_locked", LOCKED, 1'b0);
    chk("rst_dig_cnt", DIG_CNT, 3'd0);
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    // Arm then disarm
    enter_code(CODE_T);
    chk("armed_key", KEY, key_m);
    enter_code(CODE_T);
    chk("disarmed_key", KEY, key_m);

    // Wrong code then correct code
    enter_code(8'hE4);
    chk("wrong_key", KEY, key_m);
    enter_code(CODE_T);
    chk("recover_key", KEY, key_m);

    // Lockout
    fell = 1'b0;
    repeat (N_FAIL) enter_code(8'hE4);
    chk("locked_high", LOCKED, lock_m);
    enter_code(CODE_T);
    chk("locked_ignore_key", KEY, key_m);
    for (int i = 0; i < 11000 && !fell; i++) @(negedge CLK);
    chk("lock_fall_seen", fell, 1'b1);
    chk("lock_duration", fall_cyc - rise_cyc, LOCK_CYC);
    lock_m = 1'b0; fail_m = 0;
    chk("unlocked", LOCKED, lock_m);
    enter_code(CODE_T);
    chk("post_lock_key", KEY, key_m);

    // Timeout: just before expiry the partial entry is kept, after it is gone
    press(4'b0001);
    press(4'b0010);
    repeat (4900) @(negedge CLK);
    chk("pre_timeout_dig", DIG_CNT, 3'd2);
    repeat (100) @(negedge CLK);
    dc_m = 0;
    chk("timeout_dig", DIG_CNT, dc_m);
    enter_code(CODE_T);
    chk("post_timeout_key", KEY, key_m);

    // Bouncy short pulses never register
    repeat (4) begin
      @(negedge CLK) BTN = 4'b0100;
      repeat (3) @(negedge CLK);
      BTN = 4'b0000;
      repeat (3) @(negedge CLK);
    end
    repeat (30) @(negedge CLK);
    chk("glitch_dig", DIG_CNT, dc_m);

    // Simultaneous press forces a mismatch
    press(4'b0001);
    press(4'b0011);
    press(4'b0100);
    press(4'b1000);
    chk("multi_key", KEY, key_m);

    // Asynchronous reset mid-entry
    press(4'b0001);
    press(4'b0010);
    chk("pre_rst_key", KEY, key_m);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("arst_key", KEY, 2'b00);
    chk("arst_dig_cnt", DIG_CNT, 3'd0);
    chk("arst_locked", LOCKED, 1'b0);
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    // Reset during lockout
    repeat (N_FAIL) enter_code(8'hE4);
    chk("lock2_high", LOCKED, lock_m);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("arst_lock_locked", LOCKED, 1'b0);
    chk("arst_lock_key", KEY, 2'b00);
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    enter_code(CODE_T);
    chk("post_rst_key", KEY, key_m);

    repeat (20) @(negedge CLK);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
